// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: scoreboard entry layout and stage numbering.
package pipeline_pkg;

  localparam int REG_AW = 5;

  // Forwarding select encoding: 0 = register file, k = result of stage k.
  localparam int SEL_RF  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  // One in-flight destination write.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rw;
    logic              we;
    logic              ld;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority encoder: youngest in-flight write to the source
// register gives the forwarding stage; a load too young to forward is a hazard.
module fwd_match
  import pipeline_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH:1] entries_i,
  input  logic [REG_AW-1:0]   r_i,
  input  logic                used_i,
  input  logic                valid_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic                haz_o
);

  // Scan oldest to youngest so the smallest matching stage is the one kept.
  always_comb begin
    sel_o = '0;
    haz_o = 1'b0;
    if (valid_i && used_i && (r_i != '0)) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries_i[k].v && entries_i[k].we && (entries_i[k].rw == r_i)) begin
          sel_o = SEL_W'(k);
          haz_o = entries_i[k].ld && (k < LOAD_STAGE);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight destination writes in its own
// shift pipe and produces operand forwarding selects and the load-use bubble.
module hazard_scoreboard #(
  parameter  int REG_AW     = pipeline_pkg::REG_AW,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_ra_used,
  input  logic              id_rb_used,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hold,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              bubble,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import pipeline_pkg::*;

  localparam int PKG_AW = pipeline_pkg::REG_AW;
  localparam logic [SEL_W:0] SEL_MAX = (SEL_W + 1)'(DEPTH);

  // The entry struct carries the package register width; narrower indices are zero-extended.
  if (DEPTH < 2 || LOAD_STAGE < 1 || LOAD_STAGE >= DEPTH || REG_AW > PKG_AW) begin : g_bad_params
    $error("hazard_scoreboard: illegal DEPTH/LOAD_STAGE/REG_AW combination");
  end

  sb_entry_t [DEPTH:1] entry_q, entry_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                haz_a, haz_b;

  fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_match_a (
    .entries_i (entry_q),
    .r_i       (PKG_AW'(id_ra)),
    .used_i    (id_ra_used),
    .valid_i   (id_valid),
    .sel_o     (fwd_a_sel),
    .haz_o     (haz_a)
  );

  fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_match_b (
    .entries_i (entry_q),
    .r_i       (PKG_AW'(id_rb)),
    .used_i    (id_rb_used),
    .valid_i   (id_valid),
    .sel_o     (fwd_b_sel),
    .haz_o     (haz_b)
  );

  // Flush and hold both suppress the stall: a killed or frozen instruction needs no bubble.
  assign bubble = (haz_a | haz_b) & ~flush & ~hold;

  // Advance the pipe and the saturating counters unless frozen.
  always_comb begin
    entry_d      = entry_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      entry_d[1].v  = id_valid & ~bubble & ~flush;
      entry_d[1].rw = PKG_AW'(id_rw);
      entry_d[1].we = id_we;
      entry_d[1].ld = id_is_load;
      if (bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))   flush_cnt_d  = flush_cnt_q + 1'b1;
    end
  end

  // State register; reset forgets every in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q      <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      entry_q      <= entry_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // Selects must always name the register file or a tracked stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (({1'b0, fwd_a_sel} <= SEL_MAX) && ({1'b0, fwd_b_sel} <= SEL_MAX));
    end
  end

endmodule
